mmio_uart_ctrl: RTL and testbench

MMIO_UART_CTRL -- requirements
Module: mmio_uart_ctrl

---
 rtl/mmio_uart_ctrl.sv | 159 +++++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: memory-mapped UART front end.
// The CPU pushes TX bytes and pops RX bytes through small FIFOs.
// The block also exposes sticky loss flags, a free-running cycle counter
// and a retired-instruction counter.
// Loads return registered data one cycle after the strobe.
module mmio_uart_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  output logic [7:0]  data_in,
  output logic        data_in_valid,
  input  logic        data_in_ready,
  input  logic [7:0]  data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_cnt;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_cnt;
  logic          tx_drop, rx_ovf;
  logic [31:0]   cyc_cnt, inst_cnt;

  logic          sel, rd_sel, wr_sel;
  logic [7:0]    off;
  logic          tx_full, tx_ready, rx_full, rx_valid;
  logic          tx_pop, tx_push_req, tx_push, tx_drop_evt;
  logic          rx_pop, rx_push, rx_ovf_evt;
  logic          stat_rd, cnt_clr;
  logic [7:0]    tx_cnt8, rx_cnt8;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign sel    = (addr[31:28] == BASE_ADDR[31:28]);
  assign off    = addr[7:0];
  assign rd_sel = re && sel;
  assign wr_sel = we && sel;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_ready = !tx_full;
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_valid = (rx_cnt != '0);

  assign data_in        = tx_mem[tx_rp];
  assign data_in_valid  = (tx_cnt != '0);
  assign data_out_ready = 1'b1;

  // A full FIFO still accepts a push when it is popped in the same cycle,
  // so only a push that finds no room is counted as a loss.
  assign tx_pop      = data_in_valid && data_in_ready;
  assign tx_push_req = wr_sel && (off == 8'h08);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop_evt = tx_push_req && tx_full && !tx_pop;

  assign rx_pop     = rd_sel && (off == 8'h04) && rx_valid;
  assign rx_push    = data_out_valid && (!rx_full || rx_pop);
  assign rx_ovf_evt = data_out_valid && rx_full && !rx_pop;

  assign stat_rd = rd_sel && (off == 8'h00);
  assign cnt_clr = wr_sel && (off == 8'h18);

  assign tx_cnt8 = 8'(tx_cnt);
  assign rx_cnt8 = 8'(rx_cnt);

  // Upper address bits and upper store data have no meaning in this map.
  assign unused_bits = ^{addr[27:8], wdata[31:8]};

  // Load data mux; it sees the head and counter values before this cycle's updates.
  always_comb begin
    rd_mux = '0;
    case (off)
      8'h00:   rd_mux = {28'b0, tx_drop, rx_ovf, rx_valid, tx_ready};
      8'h04:   rd_mux = rx_valid ? {24'b0, rx_mem[rx_rp]} : 32'h0;
      8'h10:   rd_mux = cyc_cnt;
      8'h14:   rd_mux = inst_cnt;
      8'h1C:   rd_mux = {16'b0, tx_cnt8, rx_cnt8};
      default: rd_mux = '0;
    endcase
  end

  // FIFO storage (contents are don't-care while empty, so no reset needed)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= data_out;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
      else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CNT_ONE;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
      else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CNT_ONE;
    end
  end

  // Sticky loss flags: a status read clears them, but a new loss in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_drop <= 1'b0;
      rx_ovf  <= 1'b0;
    end else begin
      tx_drop <= tx_drop_evt || (tx_drop && !stat_rd);
      rx_ovf  <= rx_ovf_evt  || (rx_ovf  && !stat_rd);
    end
  end

  // Cycle and instruction counters; a clear overrides the same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  // Registered load data; it holds its value when no selected read is present.
  always_ff @(posedge clk) begin
    if (rst)         rdata <= '0;
    else if (rd_sel) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: a register-access vector table plus
// hand-written sequences for FIFO full/empty, flag clearing and counter clear.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, inst_retire;
  logic [7:0]  data_in, data_out;
  logic        data_in_valid, data_in_ready, data_out_valid, data_out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] B = 32'h8000_0000;

  mmio_uart_ctrl #(.FIFO_DEPTH(8), .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .inst_retire(inst_retire), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    do_read(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    vecs[0]  = '{1'b0, B | 32'h00, 32'h0,  32'h1,   "stat_idle"};
    vecs[1]  = '{1'b0, B | 32'h1C, 32'h0,  32'h0,   "cnt_empty"};
    vecs[2]  = '{1'b0, B | 32'h04, 32'h0,  32'h0,   "rx_empty"};
    vecs[3]  = '{1'b0, B | 32'h0C, 32'h0,  32'h0,   "unmapped"};
    vecs[4]  = '{1'b1, B | 32'h08, 32'h41, 32'h0,   "wr41"};
    vecs[5]  = '{1'b1, B | 32'h08, 32'h42, 32'h0,   "wr42"};
    vecs[6]  = '{1'b0, B | 32'h1C, 32'h0,  32'h200, "cnt_tx2"};
    vecs[7]  = '{1'b0, B | 32'h00, 32'h0,  32'h1,   "stat_tx2"};
    vecs[8]  = '{1'b0, 32'h9000_0000, 32'h0, 32'h1, "unsel_hold"};
    vecs[9]  = '{1'b1, 32'h9000_0008, 32'h55, 32'h0, "unsel_wr"};
    vecs[10] = '{1'b0, B | 32'h11C, 32'h0, 32'h200, "cnt_alias"};

    rst = 1'b1; addr = '0; wdata = '0; we = 0; re = 0; inst_retire = 0;
    data_in_ready = 0; data_out = '0; data_out_valid = 0;
    tick(); tick(); tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", {31'b0, data_in_valid}, 32'h0);
    rst = 1'b0;

    // Status after reset, then cycle counter after 10 idle cycles
    rd_chk("stat_rst", B | 32'h00, 32'h1);
    repeat (10) tick();
    rd_chk("cyc_cnt", B | 32'h10, 32'd11);

    // Register-access table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d);
      else begin
        do_read(vecs[i].a, d);
        chk(vecs[i].name, d, vecs[i].exp);
      end
    end

    // TX drain in order
    chk("tx_valid", {31'b0, data_in_valid}, 32'h1);
    chk("tx_head0", {24'b0, data_in}, 32'h41);
    data_in_ready = 1'b1;
    tick();
    chk("tx_head1", {24'b0, data_in}, 32'h42);
    tick();
    chk("tx_empty", {31'b0, data_in_valid}, 32'h0);
    data_in_ready = 1'b0;

    // TX overflow: ninth write dropped
    for (int i = 0; i < 9; i++) do_write(B | 32'h08, 32'h50 + i);
    rd_chk("stat_drop", B | 32'h00, 32'h8);
    rd_chk("stat_clr", B | 32'h00, 32'h0);
    rd_chk("cnt_txfull", B | 32'h1C, 32'h800);

    // RX overflow (TX still full)
    data_out_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      data_out = 8'(i);
      tick();
    end
    data_out_valid = 1'b0;
    rd_chk("stat_ovf", B | 32'h00, 32'h6);
    rd_chk("cnt_rxfull", B | 32'h1C, 32'h808);
    for (int i = 1; i <= 8; i++) rd_chk("rx_pop", B | 32'h04, 32'(i));
    rd_chk("rx_pop_empty", B | 32'h04, 32'h0);

    // RX full with same-cycle push and pop
    data_out_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_out = 8'h11 + 8'(i);
      tick();
    end
    data_out = 8'h99;
    addr = B | 32'h04; re = 1'b1;
    tick();
    re = 1'b0; data_out_valid = 1'b0;
    chk("rx_full_pp", rdata, 32'h11);
    rd_chk("stat_no_ovf", B | 32'h00, 32'h2);
    rd_chk("cnt_rx8", B | 32'h1C, 32'h808);
    for (int i = 0; i < 7; i++) rd_chk("rx_drain", B | 32'h04, 32'h12 + i);
    rd_chk("rx_drain_last", B | 32'h04, 32'h99);

    // TX full with same-cycle push and pop
    data_in_ready = 1'b1;
    addr = B | 32'h08; wdata = 32'h77; we = 1'b1;
    tick();
    we = 1'b0; data_in_ready = 1'b0;
    rd_chk("cnt_tx_pp", B | 32'h1C, 32'h800);
    rd_chk("stat_no_drop", B | 32'h00, 32'h0);
    data_in_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("tx_order", {24'b0, data_in}, 32'h51 + i);
      tick();
    end
    chk("tx_order_last", {24'b0, data_in}, 32'h77);
    tick();
    chk("tx_drained", {31'b0, data_in_valid}, 32'h0);
    data_in_ready = 1'b0;

    // Instruction counter and clear
    for (int i = 0; i < 5; i++) begin
      inst_retire = 1'b1; tick();
      inst_retire = 1'b0; tick();
    end
    rd_chk("inst5", B | 32'h14, 32'd5);
    do_write(B | 32'h18, 32'h1234);
    rd_chk("cyc_clr", B | 32'h10, 32'h0);
    rd_chk("inst_clr", B | 32'h14, 32'h0);
    inst_retire = 1'b1; tick(); inst_retire = 1'b0;
    inst_retire = 1'b1;
    do_write(B | 32'h18, 32'h0);
    inst_retire = 1'b0;
    rd_chk("inst_clr_win", B | 32'h14, 32'h0);

    // Reset mid-transfer
    do_write(B | 32'h08, 32'hAA);
    data_out_valid = 1'b1; data_out = 8'h33; tick(); data_out_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_valid", {31'b0, data_in_valid}, 32'h0);
    rd_chk("rst_mid_cnt", B | 32'h1C, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
